txt_ram_arbiter: RTL and testbench

- Arbitrates the single-port text/attribute RAM (68k window 0x068000-0x069fff, low byte only) between the 68k and the text-layer video fetcher.
- Drives RAM address, data and write enable, and generates DTACK for 68k text-RAM cycles.
- Video fetches have priority. A starvation counter guarantees the 68k a slot after MAX_VID back-to-back video grants.
- Sits between the chip-select decode (txt_ram_cs) and the text RAM BRAM.

---
 rtl/txt_ram_arbiter_if.sv | 37 +++
 rtl/txt_ram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_txt_ram_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/txt_ram_arbiter_if.sv
// Text-RAM arbiter bus bundle: 68k side, video fetch side and the BRAM port.
// master = surrounding system (decode, fetcher, BRAM), slave = arbiter.
interface txt_ram_arbiter_if #(
    parameter int unsigned AW = 12
);
    logic          txt_ram_cs;
    logic [AW-1:0] m68k_a;
    logic          m68k_rw;
    logic          m68k_lds_n;
    logic [7:0]    m68k_din;
    logic [15:0]   m68k_dout;
    logic          m68k_dtack_n;

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic          vid_valid;

    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;

    modport master (
        output txt_ram_cs, m68k_a, m68k_rw, m68k_lds_n, m68k_din,
        output vid_req, vid_addr, ram_dout,
        input  m68k_dout, m68k_dtack_n, vid_data, vid_valid,
        input  ram_addr, ram_din, ram_we
    );

    modport slave (
        input  txt_ram_cs, m68k_a, m68k_rw, m68k_lds_n, m68k_din,
        input  vid_req, vid_addr, ram_dout,
        output m68k_dout, m68k_dtack_n, vid_data, vid_valid,
        output ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/txt_ram_arbiter.sv
// Single-port text RAM arbiter: video fetch priority, 68k starvation guard, DTACK.
// Optional TXT_ARB_STATS_EN adds cpu_wait_max / stats_clr (worst 68k wait).
module txt_ram_arbiter #(
    parameter int unsigned AW      = 12,
    parameter int unsigned RAM_LAT = 1,
    parameter int unsigned MAX_VID = 4
) (
    input  logic             clk_sys,
    input  logic             reset_n,
`ifdef TXT_ARB_STATS_EN
    input  logic             stats_clr,
    output logic [7:0]       cpu_wait_max,
`endif
    txt_ram_arbiter_if.slave bus
);
    localparam int unsigned SW = (MAX_VID < 1) ? 1 : $clog2(MAX_VID + 1);
    localparam int unsigned LW = 2;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_VID);
    localparam logic [LW-1:0] LAT_LAST   = LW'(RAM_LAT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        VID_RD  = 3'd1,
        CPU_RD  = 3'd2,
        CPU_WR  = 3'd3,
        CPU_ACK = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_vid_pend;
    logic [AW-1:0] r_vid_addr;
    logic          r_cpu_served;
    logic [SW-1:0] r_starve;
    logic [LW-1:0] r_lat;
    logic [AW-1:0] r_ram_addr;
    logic [7:0]    r_ram_din;
    logic          r_ram_we;
    logic [15:0]   r_m68k_dout;
    logic          r_dtack_n;
    logic [7:0]    r_vid_data;
    logic          r_vid_valid;

    logic          w_cpu_pend;
    logic          w_vid_pend;
    logic [AW-1:0] w_vid_addr;
    logic          w_vid_win;
    logic          w_cpu_grant;

    // A request pulse arriving in IDLE is granted the same clock it is seen.
    assign w_cpu_pend  = bus.txt_ram_cs & ~r_cpu_served;
    assign w_vid_pend  = r_vid_pend | bus.vid_req;
    assign w_vid_addr  = bus.vid_req ? bus.vid_addr : r_vid_addr;
    assign w_vid_win   = (r_state == IDLE) && w_vid_pend &&
                         (!w_cpu_pend || (r_starve < STARVE_MAX));
    assign w_cpu_grant = (r_state == IDLE) && w_cpu_pend && !w_vid_win;

    assign bus.ram_addr     = r_ram_addr;
    assign bus.ram_din      = r_ram_din;
    assign bus.ram_we       = r_ram_we;
    assign bus.m68k_dout    = r_m68k_dout;
    assign bus.m68k_dtack_n = r_dtack_n;
    assign bus.vid_data     = r_vid_data;
    assign bus.vid_valid    = r_vid_valid;

    // Pending video fetch; a newer pulse replaces an ungranted address.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_vid_pend <= 1'b0;
            r_vid_addr <= '0;
        end else if (w_vid_win) begin
            r_vid_pend <= 1'b0;
        end else if (bus.vid_req) begin
            r_vid_pend <= 1'b1;
            r_vid_addr <= bus.vid_addr;
        end
    end

    // One grant per 68k bus cycle; re-armed when the select drops.
    always_ff @(posedge clk_sys) begin
        if (!reset_n || !bus.txt_ram_cs) begin
            r_cpu_served <= 1'b0;
        end else if (w_cpu_grant) begin
            r_cpu_served <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_starve    <= '0;
            r_lat       <= '0;
            r_ram_addr  <= '0;
            r_ram_din   <= 8'h00;
            r_ram_we    <= 1'b0;
            r_m68k_dout <= 16'hffff;
            r_dtack_n   <= 1'b1;
            r_vid_data  <= 8'h00;
            r_vid_valid <= 1'b0;
        end else begin
            r_ram_we    <= 1'b0;
            r_vid_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_lat <= '0;
                    if (w_vid_win) begin
                        r_state    <= VID_RD;
                        r_ram_addr <= w_vid_addr;
                        if (w_cpu_pend) begin
                            r_starve <= r_starve + SW'(1);
                        end
                    end else if (w_cpu_grant) begin
                        r_starve   <= '0;
                        r_ram_addr <= bus.m68k_a;
                        if (bus.m68k_rw) begin
                            r_state <= CPU_RD;
                        end else begin
                            r_state   <= CPU_WR;
                            r_ram_din <= bus.m68k_din;
                            r_ram_we  <= ~bus.m68k_lds_n;
                        end
                    end
                end
                VID_RD: begin
                    if (r_lat == LAT_LAST) begin
                        r_vid_data  <= bus.ram_dout;
                        r_vid_valid <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                CPU_RD: begin
                    // DTACK goes out with the data unless the cycle was abandoned.
                    if (r_lat == LAT_LAST) begin
                        r_m68k_dout <= {8'hff, bus.ram_dout};
                        r_dtack_n   <= ~bus.txt_ram_cs;
                        r_state     <= CPU_ACK;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                CPU_WR: begin
                    r_state <= CPU_ACK;
                end
                CPU_ACK: begin
                    r_starve <= '0;
                    if (!bus.txt_ram_cs) begin
                        r_dtack_n <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_dtack_n <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef TXT_ARB_STATS_EN
    logic [7:0] r_wait_cnt;
    logic [7:0] r_wait_max;

    // Clocks a 68k request sat pending before its grant, worst case kept.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_wait_cnt <= 8'h00;
            r_wait_max <= 8'h00;
        end else begin
            if (w_cpu_grant || !w_cpu_pend) begin
                r_wait_cnt <= 8'h00;
            end else if (r_wait_cnt != 8'hff) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (stats_clr) begin
                r_wait_max <= 8'h00;
            end else if (w_cpu_grant && (r_wait_cnt > r_wait_max)) begin
                r_wait_max <= r_wait_cnt;
            end
        end
    end

    assign cpu_wait_max = r_wait_max;
`endif
endmodule

// File: tb/tb_txt_ram_arbiter.sv
// Self-checking bench for txt_ram_arbiter: directed latency/priority cases plus
// randomized 68k/video traffic scored against a golden RAM image.
module tb_txt_ram_arbiter;
    localparam int unsigned AW      = 12;
    localparam int unsigned MAX_VID = 4;
    localparam int unsigned N_RND   = 120;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rnd_on;

    logic [7:0]  mem  [0:4095];
    logic [7:0]  gmem [0:4095];
    logic [12:0] fill_idx = 13'd0;

    txt_ram_arbiter_if #(.AW(AW)) bus ();

`ifdef TXT_ARB_STATS_EN
    logic       stats_clr;
    logic [7:0] cpu_wait_max;
`endif

    txt_ram_arbiter #(
        .AW      (AW),
        .RAM_LAT (1),
        .MAX_VID (MAX_VID)
    ) dut (
        .clk_sys      (clk),
        .reset_n      (reset_n),
`ifdef TXT_ARB_STATS_EN
        .stats_clr    (stats_clr),
        .cpu_wait_max (cpu_wait_max),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seed_byte(input int unsigned a);
        if (a == 32'h3ff) return 8'hc3;
        return 8'((a * 7 + 60) ^ (a >> 4));
    endfunction

    // BRAM model, read latency 1; preloads itself one byte per clock at start.
    always @(posedge clk) begin
        if (!fill_idx[12]) begin
            mem[fill_idx[11:0]] <= seed_byte(32'(fill_idx));
            fill_idx <= fill_idx + 13'd1;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_din;
        end
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One 68k bus cycle; lat = clocks from the select being seen to DTACK low.
    task automatic cpu_access(input logic rw, input logic [AW-1:0] a, input logic [7:0] d,
                              input logic lds_n, output int lat, output logic [15:0] rdata,
                              output int we_cnt, output int we_at);
        bus.txt_ram_cs = 1'b1;
        bus.m68k_rw    = rw;
        bus.m68k_a     = a;
        bus.m68k_din   = d;
        bus.m68k_lds_n = lds_n;
        lat = -1;
        we_cnt = 0;
        we_at = -1;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.ram_we) begin
                we_cnt++;
                if (we_at < 0) we_at = c;
                check_eq("we_addr", 32'(bus.ram_addr), 32'(a));
                check_eq("we_din", 32'(bus.ram_din), 32'(d));
            end
            if (!bus.m68k_dtack_n) lat = c;
        end
        rdata = bus.m68k_dout;
        bus.txt_ram_cs = 1'b0;
        @(negedge clk);
        check_eq("dtack_release", 32'(bus.m68k_dtack_n), 32'h1);
    endtask

    task automatic vid_fetch(input logic [AW-1:0] a, output int lat, output logic [7:0] data);
        bus.vid_req  = 1'b1;
        bus.vid_addr = a;
        lat = -1;
        data = 8'h00;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            bus.vid_req = 1'b0;
            if (bus.vid_valid) begin
                lat = c;
                data = bus.vid_data;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, we_cnt, we_at, vat, wat, vcnt;
        logic [15:0] rd;
        logic [7:0]  vd, old;
        logic        seen;

        bus.txt_ram_cs = 1'b0;
        bus.m68k_a     = '0;
        bus.m68k_rw    = 1'b1;
        bus.m68k_lds_n = 1'b1;
        bus.m68k_din   = 8'h00;
        bus.vid_req    = 1'b0;
        bus.vid_addr   = '0;
        rnd_on         = 1'b0;
`ifdef TXT_ARB_STATS_EN
        stats_clr      = 1'b0;
`endif
        for (int i = 0; i < 4096; i++) gmem[i] = seed_byte(32'(i));
        reset_n = 1'b0;
        repeat (4100) @(negedge clk);

        check_eq("rst_dtack_n", 32'(bus.m68k_dtack_n), 32'h1);
        check_eq("rst_vid_valid", 32'(bus.vid_valid), 32'h0);
        check_eq("rst_ram_we", 32'(bus.ram_we), 32'h0);
        check_eq("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        check_eq("rst_ram_din", 32'(bus.ram_din), 32'h0);
        check_eq("rst_m68k_dout", 32'(bus.m68k_dout), 32'hffff);
        check_eq("rst_vid_data", 32'(bus.vid_data), 32'h0);
`ifdef TXT_ARB_STATS_EN
        check_eq("rst_wait_max", 32'(cpu_wait_max), 32'h0);
`endif
        reset_n = 1'b1;
        @(negedge clk);

        // Write 0x5a to word 0x010, then read it back.
        cpu_access(1'b0, 12'h010, 8'h5a, 1'b0, lat, rd, we_cnt, we_at);
        check_eq("wr_lat", 32'(lat), 32'd2);
        check_eq("wr_we_cnt", 32'(we_cnt), 32'd1);
        check_eq("wr_we_at", 32'(we_at), 32'd0);
        gmem[12'h010] = 8'h5a;
        cpu_access(1'b1, 12'h010, 8'h00, 1'b0, lat, rd, we_cnt, we_at);
        check_eq("rd_lat", 32'(lat), 32'd2);
        check_eq("rd_data", 32'(rd), 32'hff5a);
        check_eq("rd_no_we", 32'(we_cnt), 32'd0);

        // Idle video fetch of the preloaded 0xc3 byte.
        vid_fetch(12'h3ff, lat, vd);
        check_eq("vid_lat", 32'(lat), 32'd2);
        check_eq("vid_data", 32'(vd), 32'hc3);
        @(negedge clk);
        check_eq("vid_valid_pulse", 32'(bus.vid_valid), 32'h0);

        // Video every other clock against a pending read: MAX_VID grants, then the 68k.
        for (int r = 0; r < 2; r++) begin
            bus.txt_ram_cs = 1'b1;
            bus.m68k_rw    = 1'b1;
            bus.m68k_a     = 12'(12'h020 + r);
            vcnt = 0;
            lat = -1;
            for (int c = 0; c < 80 && lat < 0; c++) begin
                bus.vid_req  = (c % 2 == 0);
                bus.vid_addr = 12'(12'h100 + c);
                @(negedge clk);
                if (bus.vid_valid) vcnt++;
                if (!bus.m68k_dtack_n) lat = c;
            end
            bus.vid_req = 1'b0;
            check_eq("starve_vid_grants", 32'(vcnt), 32'(MAX_VID));
            check_eq("starve_cpu_ack", 32'(lat >= 0), 32'h1);
            check_eq("starve_rd_data", 32'(bus.m68k_dout), 32'({8'hff, gmem[12'(12'h020 + r)]}));
            bus.txt_ram_cs = 1'b0;
            repeat (8) @(negedge clk);
        end

        // Same-clock video fetch and 68k write to one address: video sees old data.
        old = gmem[12'h040];
        bus.vid_req    = 1'b1;
        bus.vid_addr   = 12'h040;
        bus.txt_ram_cs = 1'b1;
        bus.m68k_rw    = 1'b0;
        bus.m68k_a     = 12'h040;
        bus.m68k_din   = 8'h77;
        bus.m68k_lds_n = 1'b0;
        vat = -1;
        wat = -1;
        lat = -1;
        vd  = 8'h00;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            bus.vid_req = 1'b0;
            if (bus.vid_valid && vat < 0) begin
                vat = c;
                vd  = bus.vid_data;
            end
            if (bus.ram_we && wat < 0) wat = c;
            if (!bus.m68k_dtack_n) lat = c;
        end
        bus.txt_ram_cs = 1'b0;
        @(negedge clk);
        check_eq("race_vid_at", 32'(vat), 32'd2);
        check_eq("race_vid_old", 32'(vd), 32'(old));
        check_eq("race_we_at", 32'(wat), 32'd3);
        check_eq("race_ack_at", 32'(lat), 32'd5);
        gmem[12'h040] = 8'h77;
        cpu_access(1'b1, 12'h040, 8'h00, 1'b0, lat, rd, we_cnt, we_at);
        check_eq("race_readback", 32'(rd), 32'hff77);

        // Upper-byte-only write: handshake completes, RAM untouched.
        cpu_access(1'b0, 12'h050, 8'ha5, 1'b1, lat, rd, we_cnt, we_at);
        check_eq("ub_we_cnt", 32'(we_cnt), 32'd0);
        check_eq("ub_lat", 32'(lat), 32'd2);
        cpu_access(1'b1, 12'h050, 8'h00, 1'b0, lat, rd, we_cnt, we_at);
        check_eq("ub_readback", 32'(rd), 32'({8'hff, gmem[12'h050]}));

        // Reset in the middle of a 68k read.
        bus.txt_ram_cs = 1'b1;
        bus.m68k_rw    = 1'b1;
        bus.m68k_a     = 12'h060;
        @(negedge clk);
        reset_n = 1'b0;
        bus.txt_ram_cs = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_dtack_n", 32'(bus.m68k_dtack_n), 32'h1);
        check_eq("mid_rst_dout", 32'(bus.m68k_dout), 32'hffff);
        check_eq("mid_rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        reset_n = 1'b1;
        vid_fetch(12'h3ff, lat, vd);
        check_eq("post_rst_vid_lat", 32'(lat), 32'd2);

        // Reset during a video fetch drops it silently.
        bus.vid_req  = 1'b1;
        bus.vid_addr = 12'h3ff;
        @(negedge clk);
        bus.vid_req = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.vid_valid) seen = 1'b1;
        end
        check_eq("rst_drop_vid", 32'(seen), 32'h0);

        // Random mixed traffic: 68k in the low half, video in the high half.
        rnd_on = 1'b1;
        fork
            begin : cpu_proc
                int          rl, rwc, rwa;
                logic [15:0] rrd;
                logic        rrw, rlds;
                logic [AW-1:0] ra;
                logic [7:0]  rdat;
                for (int t = 0; t < N_RND; t++) begin
                    rrw  = 1'($urandom_range(0, 1));
                    ra   = 12'($urandom_range(0, 12'h7ff));
                    rdat = 8'($urandom);
                    rlds = ($urandom_range(0, 4) == 0);
                    cpu_access(rrw, ra, rdat, rlds, rl, rrd, rwc, rwa);
                    check_eq("rnd_ack", 32'(rl >= 0), 32'h1);
                    if (rrw) begin
                        check_eq("rnd_rd_data", 32'(rrd), 32'({8'hff, gmem[ra]}));
                    end else begin
                        check_eq("rnd_we_cnt", 32'(rwc), 32'(!rlds));
                        if (!rlds) gmem[ra] = rdat;
                    end
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                rnd_on = 1'b0;
            end
            begin : vid_proc
                logic          busy;
                logic [AW-1:0] va;
                int            age;
                busy = 1'b0;
                va   = '0;
                age  = 0;
                while (rnd_on || busy) begin
                    @(negedge clk);
                    bus.vid_req = 1'b0;
                    if (bus.vid_valid) begin
                        check_eq("rnd_vid_owner", 32'(busy), 32'h1);
                        check_eq("rnd_vid_data", 32'(bus.vid_data), 32'(gmem[va]));
                        busy = 1'b0;
                    end else if (busy) begin
                        age++;
                        if (age > 30) begin
                            check_eq("rnd_vid_timeout", 32'(bus.vid_valid), 32'h1);
                            busy = 1'b0;
                        end
                    end
                    if (!busy && rnd_on && $urandom_range(0, 2) == 0) begin
                        va           = 12'h800 | 12'($urandom_range(0, 12'h7ff));
                        bus.vid_addr = va;
                        bus.vid_req  = 1'b1;
                        busy         = 1'b1;
                        age          = 0;
                    end
                end
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
